dispense_job_scheduler: RTL and testbench
=========================================

Name: dispense_job_scheduler

Overview:
- Sits directly upstream of the stepper-motor dispenser.
- Accepts colour orders (4-bit colour_id) from the user-input front end and buffers them in a small FIFO.
- Translates each order into red/yellow/blue drop-round counts via a fixed recipe table.
- Issues one job at a time to the dispenser over a valid/ack handshake, waits for job_done, then enforces an inter-job gap before the next job.

Parameters:
- DEPTH, 4, order FIFO depth; power of two, ≥2.
- ROUND_W, 10, width of each round-count output.
- GAP_CYCLES, 2, idle cycles inserted after job_done before the next pop; 0 means no gap.
- TIMEOUT_CYCLES, 1000000, BUSY watchdog limit; used only with JOB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- order_valid  in  1  order present
- order_color  in  4  requested colour_id
- order_ready  out  1  FIFO can accept; equals !full
- order_err  out  1  one-cycle pulse; the accepted order had an invalid colour
- job_valid  out  1  job fields valid; held until acked
- job_r_rounds  out  ROUND_W  red drop rounds
- job_y_rounds  out  ROUND_W  yellow drop rounds
- job_b_rounds  out  ROUND_W  blue drop rounds
- job_ack  in  1  dispenser took the job
- job_done  in  1  one-cycle pulse; dispenser finished
- job_abort  out  1  one-cycle pulse on watchdog expiry
- busy  out  1  state != IDLE
- pending  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset values: all outputs 0, except order_ready=1. FIFO empty, pointers 0, state IDLE, all counters 0. Reset mid-job drops the job and all queued orders.
- Order acceptance: handshake is order_valid && order_ready.
  - Colours 0–7 are written to the FIFO.
  - Colours 8–15 are not written; order_err goes high on the following cycle for exactly 1 cycle.
- FIFO behaviour:
  - Push while full cannot occur, because ready is low when full. There is no bypass.
  - Push and pop in the same cycle (non-empty, non-full): occupancy unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- Recipe table (r/y/b rounds), zero-extended to ROUND_W:
  - 0: 5/9/9
  - 1: 10/0/0
  - 2: 0/10/0
  - 3: 0/0/10
  - 4: 5/5/0
  - 5: 0/5/5
  - 6: 5/0/5
  - 7: 3/3/3
- FSM states: IDLE, ISSUE, BUSY, GAP. All outputs are registered.
  - IDLE: if pending != 0, pop the head, latch the recipe into the job_* fields, go to ISSUE.
  - ISSUE: job_valid=1, fields stable. On job_ack, go to BUSY; job_valid is 0 in the next cycle.
  - BUSY: on job_done, go to GAP with the gap counter cleared. If GAP_CYCLES=0, go directly to IDLE.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- Ignored inputs: job_ack outside ISSUE, and job_done outside BUSY (including during ISSUE).
- job_* fields hold their last values after job_valid drops.
- Latency: order accepted at edge N into an empty FIFO with the FSM in IDLE gives job_valid=1 after edge N+2.
- Back-to-back throughput: with GAP_CYCLES=2 and an immediate ack, the next job_valid rises 4 cycles after the job_done edge (1 BUSY→GAP, 2 gap, 1 pop).

Optional Feature:
- Macro: JOB_TIMEOUT_EN
- Defined:
  - A BUSY-cycle counter clears on entry to BUSY.
  - If it reaches TIMEOUT_CYCLES without job_done, job_abort pulses for 1 cycle and the FSM goes to GAP.
  - job_done in the same cycle as expiry takes priority: no abort is raised.
- Not defined: job_abort is tied to 0 and BUSY waits indefinitely for job_done.

Test Plan:
- Reset, then push colour 0 → job_valid=1 two cycles later with r/y/b=5/9/9; ack; job_done → busy stays 1 for 2 gap cycles, then returns to 0.
- Push colours 1,2,3,4 back-to-back with no ack → pending=4 and order_ready=0; the 5th order_valid is held off; acking in sequence yields 10/0/0, 0/10/0, 0/0/10, 5/5/0 in that order.
- Push colour 12 → order_err pulses 1 cycle; pending unchanged; no job issued.
- Push while popping (pending=2, FSM in IDLE) → pending stays 2; FIFO order is preserved across pointer wrap after 6 orders.
- Assert rst during BUSY with 3 orders pending → all outputs 0 immediately; order_ready=1; no job issues after release until a new push.
- With JOB_TIMEOUT_EN and TIMEOUT_CYCLES=20, withhold job_done → job_abort pulses after 20 BUSY cycles; the next queued job issues after the gap.

Source files
------------

// File: rtl/dispense_job_scheduler.sv
// Order FIFO plus job FSM that turns colour orders into r/y/b drop-round jobs for the dispenser.
// Optional BUSY watchdog is compiled in with `define JOB_TIMEOUT_EN.
module dispense_job_scheduler #(
    parameter int DEPTH          = 4,
    parameter int ROUND_W        = 10,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       order_valid,
    input  logic [3:0]                 order_color,
    output logic                       order_ready,
    output logic                       order_err,
    output logic                       job_valid,
    output logic [ROUND_W-1:0]         job_r_rounds,
    output logic [ROUND_W-1:0]         job_y_rounds,
    output logic [ROUND_W-1:0]         job_b_rounds,
    input  logic                       job_ack,
    input  logic                       job_done,
    output logic                       job_abort,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] pending
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 2);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
`ifdef JOB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, GAP} state_t;

    state_t             state_q, state_d;
    logic [2:0]         mem_q [DEPTH];
    logic [2:0]         mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               order_err_q, order_err_d;
    logic               job_valid_q, job_valid_d;
    logic               job_abort_q, job_abort_d;
    logic               busy_q, busy_d;
    logic [ROUND_W-1:0] r_q, r_d, y_q, y_d, b_q, b_d;
    logic               full, accept, push, pop, timeout;

    function automatic logic [3*ROUND_W-1:0] recipe(input logic [2:0] c);
        case (c)
            3'd0:    recipe = {ROUND_W'(5),  ROUND_W'(9),  ROUND_W'(9)};
            3'd1:    recipe = {ROUND_W'(10), ROUND_W'(0),  ROUND_W'(0)};
            3'd2:    recipe = {ROUND_W'(0),  ROUND_W'(10), ROUND_W'(0)};
            3'd3:    recipe = {ROUND_W'(0),  ROUND_W'(0),  ROUND_W'(10)};
            3'd4:    recipe = {ROUND_W'(5),  ROUND_W'(5),  ROUND_W'(0)};
            3'd5:    recipe = {ROUND_W'(0),  ROUND_W'(5),  ROUND_W'(5)};
            3'd6:    recipe = {ROUND_W'(5),  ROUND_W'(0),  ROUND_W'(5)};
            default: recipe = {ROUND_W'(3),  ROUND_W'(3),  ROUND_W'(3)};
        endcase
    endfunction

    // Invalid colours still complete the handshake; they only raise order_err.
    assign full   = (count_q == CNT_W'(DEPTH));
    assign accept = order_valid && !full;
    assign push   = accept && !order_color[3];
    assign pop    = (state_q == IDLE) && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q;
        if (push) mem_d[wr_ptr_q] = order_color[2:0];
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Watchdog counter sits at zero outside BUSY, so it is cleared on every BUSY entry.
    always_comb begin
        gap_cnt_d = (state_q == GAP) ? gap_cnt_q + GAP_W'(1) : '0;
        to_cnt_d  = (TIMEOUT_EN && state_q == BUSY) ? to_cnt_q + TO_W'(1) : '0;
        timeout   = TIMEOUT_EN && (state_q == BUSY) && !job_done &&
                    (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            gap_cnt_q   <= '0;
            to_cnt_q    <= '0;
            order_err_q <= 1'b0;
            job_valid_q <= 1'b0;
            job_abort_q <= 1'b0;
            busy_q      <= 1'b0;
            r_q         <= '0;
            y_q         <= '0;
            b_q         <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            gap_cnt_q   <= gap_cnt_d;
            to_cnt_q    <= to_cnt_d;
            order_err_q <= order_err_d;
            job_valid_q <= job_valid_d;
            job_abort_q <= job_abort_d;
            busy_q      <= busy_d;
            r_q         <= r_d;
            y_q         <= y_d;
            b_q         <= b_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop) state_d = ISSUE;
            ISSUE:   if (job_ack && job_valid_q) state_d = BUSY;
            BUSY:    if (job_done || timeout) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:     if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // job_valid trails the ISSUE entry by one cycle, so an ack only counts once it is visible.
    always_comb begin
        job_valid_d = (state_q == ISSUE) && !(job_ack && job_valid_q);
        busy_d      = (state_d != IDLE);
        order_err_d = accept && order_color[3];
        job_abort_d = timeout;
        {r_d, y_d, b_d} = {r_q, y_q, b_q};
        if (pop) {r_d, y_d, b_d} = recipe(mem_q[rd_ptr_q]);
    end

    assign order_ready  = !full;
    assign order_err    = order_err_q;
    assign job_valid    = job_valid_q;
    assign job_abort    = job_abort_q;
    assign busy         = busy_q;
    assign pending      = count_q;
    assign job_r_rounds = r_q;
    assign job_y_rounds = y_q;
    assign job_b_rounds = b_q;
endmodule

// File: tb/tb_dispense_job_scheduler.sv
// Bench for dispense_job_scheduler: table-driven order vectors plus hand-written corner sequences,
// with expected jobs queued in a scoreboard until the DUT issues them.
module tb_dispense_job_scheduler;
    localparam int DEPTH          = 4;
    localparam int ROUND_W        = 10;
    localparam int GAP_CYCLES     = 2;
    localparam int TIMEOUT_CYCLES = 20;
    localparam int NVEC           = 12;

    typedef struct packed {
        logic [ROUND_W-1:0] r;
        logic [ROUND_W-1:0] y;
        logic [ROUND_W-1:0] b;
    } job_t;

    typedef struct packed {
        logic [3:0] color;
        logic       err;
        job_t       job;
    } vec_t;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       order_valid;
    logic [3:0]                 order_color;
    logic                       order_ready;
    logic                       order_err;
    logic                       job_valid;
    logic [ROUND_W-1:0]         job_r_rounds;
    logic [ROUND_W-1:0]         job_y_rounds;
    logic [ROUND_W-1:0]         job_b_rounds;
    logic                       job_ack;
    logic                       job_done;
    logic                       job_abort;
    logic                       busy;
    logic [$clog2(DEPTH+1)-1:0] pending;

    job_t sb[$];
    vec_t vecs[NVEC];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    dispense_job_scheduler #(
        .DEPTH(DEPTH), .ROUND_W(ROUND_W), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .order_valid(order_valid), .order_color(order_color),
        .order_ready(order_ready), .order_err(order_err),
        .job_valid(job_valid), .job_r_rounds(job_r_rounds),
        .job_y_rounds(job_y_rounds), .job_b_rounds(job_b_rounds),
        .job_ack(job_ack), .job_done(job_done), .job_abort(job_abort),
        .busy(busy), .pending(pending)
    );

    function automatic job_t expRecipe(input logic [3:0] c);
        job_t j;
        case (c)
            4'd0:    j = '{r: 10'd5,  y: 10'd9,  b: 10'd9};
            4'd1:    j = '{r: 10'd10, y: 10'd0,  b: 10'd0};
            4'd2:    j = '{r: 10'd0,  y: 10'd10, b: 10'd0};
            4'd3:    j = '{r: 10'd0,  y: 10'd0,  b: 10'd10};
            4'd4:    j = '{r: 10'd5,  y: 10'd5,  b: 10'd0};
            4'd5:    j = '{r: 10'd0,  y: 10'd5,  b: 10'd5};
            4'd6:    j = '{r: 10'd5,  y: 10'd0,  b: 10'd5};
            4'd7:    j = '{r: 10'd3,  y: 10'd3,  b: 10'd3};
            default: j = '0;
        endcase
        return j;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic reportExpired(input string name);
        n_vec++;
        n_miss++;
        $display("[TB] FAIL %s: bound expired, got no event, expected one", name);
    endtask

    // Drives one order through the handshake; valid colours queue their expected job.
    task automatic applyStimulus(input logic [3:0] color, input job_t exp);
        int waited = 0;
        order_valid = 1'b1;
        order_color = color;
        while (!order_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!order_ready) begin
            order_valid = 1'b0;
            reportExpired("order_ready_wait");
            return;
        end
        tick();
        order_valid = 1'b0;
        if (color < 4'd8) sb.push_back(exp);
    endtask

    task automatic takeJob();
        int   k = 0;
        job_t e;
        while (!job_valid && k < 50) begin
            tick();
            k++;
        end
        if (!job_valid) begin
            reportExpired("job_valid_wait");
            return;
        end
        if (sb.size() == 0) begin
            reportExpired("scoreboard_unexpected_job");
            return;
        end
        e = sb.pop_front();
        checkOutput("job_r", job_r_rounds, e.r);
        checkOutput("job_y", job_y_rounds, e.y);
        checkOutput("job_b", job_b_rounds, e.b);
        job_ack = 1'b1;
        tick();
        job_ack = 1'b0;
        checkOutput("valid_after_ack", job_valid, 0);
        checkOutput("hold_r_after_ack", job_r_rounds, e.r);
    endtask

    task automatic finishJob(input int delay);
        repeat (delay) tick();
        job_done = 1'b1;
        tick();
        job_done = 1'b0;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int k;
        vecs[0]  = '{color: 4'd3,  err: 1'b0, job: '{r: 10'd0,  y: 10'd0,  b: 10'd10}};
        vecs[1]  = '{color: 4'd8,  err: 1'b1, job: '0};
        vecs[2]  = '{color: 4'd0,  err: 1'b0, job: '{r: 10'd5,  y: 10'd9,  b: 10'd9}};
        vecs[3]  = '{color: 4'd5,  err: 1'b0, job: '{r: 10'd0,  y: 10'd5,  b: 10'd5}};
        vecs[4]  = '{color: 4'd15, err: 1'b1, job: '0};
        vecs[5]  = '{color: 4'd7,  err: 1'b0, job: '{r: 10'd3,  y: 10'd3,  b: 10'd3}};
        vecs[6]  = '{color: 4'd1,  err: 1'b0, job: '{r: 10'd10, y: 10'd0,  b: 10'd0}};
        vecs[7]  = '{color: 4'd2,  err: 1'b0, job: '{r: 10'd0,  y: 10'd10, b: 10'd0}};
        vecs[8]  = '{color: 4'd6,  err: 1'b0, job: '{r: 10'd5,  y: 10'd0,  b: 10'd5}};
        vecs[9]  = '{color: 4'd4,  err: 1'b0, job: '{r: 10'd5,  y: 10'd5,  b: 10'd0}};
        vecs[10] = '{color: 4'd12, err: 1'b1, job: '0};
        vecs[11] = '{color: 4'd0,  err: 1'b0, job: '{r: 10'd5,  y: 10'd9,  b: 10'd9}};

        rst = 1'b1; order_valid = 1'b0; order_color = '0; job_ack = 1'b0; job_done = 1'b0;
        repeat (3) tick();
        checkOutput("rst_order_ready", order_ready, 1);
        checkOutput("rst_job_valid", job_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pending", pending, 0);
        checkOutput("rst_order_err", order_err, 0);
        checkOutput("rst_job_abort", job_abort, 0);
        checkOutput("rst_job_r", job_r_rounds, 0);
        rst = 1'b0;
        tick();

        $display("[TB] latency and gap with colour 0");
        applyStimulus(4'd0, expRecipe(4'd0));
        checkOutput("lat_pending_n", pending, 1);
        checkOutput("lat_valid_n", job_valid, 0);
        tick();
        checkOutput("lat_valid_n1", job_valid, 0);
        checkOutput("lat_busy_n1", busy, 1);
        checkOutput("lat_pending_n1", pending, 0);
        tick();
        checkOutput("lat_valid_n2", job_valid, 1);
        job_done = 1'b1;
        tick();
        job_done = 1'b0;
        checkOutput("done_in_issue_ignored", job_valid, 1);
        takeJob();
        finishJob(3);
        checkOutput("gap_busy_0", busy, 1);
        tick();
        checkOutput("gap_busy_1", busy, 1);
        tick();
        checkOutput("gap_busy_end", busy, 0);
        job_ack = 1'b1;
        tick();
        job_ack = 1'b0;
        checkOutput("ack_idle_ignored", busy, 0);

        $display("[TB] invalid colour");
        applyStimulus(4'd12, '0);
        checkOutput("err_pulse", order_err, 1);
        checkOutput("err_pending", pending, 0);
        tick();
        checkOutput("err_pulse_end", order_err, 0);
        tick();
        checkOutput("err_no_job", job_valid, 0);
        checkOutput("err_not_busy", busy, 0);

        $display("[TB] fill FIFO behind a busy job");
        applyStimulus(4'd7, expRecipe(4'd7));
        takeJob();
        applyStimulus(4'd1, expRecipe(4'd1));
        applyStimulus(4'd2, expRecipe(4'd2));
        applyStimulus(4'd3, expRecipe(4'd3));
        applyStimulus(4'd4, expRecipe(4'd4));
        checkOutput("full_pending", pending, 4);
        checkOutput("full_ready", order_ready, 0);
        order_valid = 1'b1;
        order_color = 4'd5;
        repeat (2) tick();
        checkOutput("held_off_pending", pending, 4);
        checkOutput("held_off_ready", order_ready, 0);
        order_valid = 1'b0;
        job_done = 1'b1;
        tick();
        job_done = 1'b0;
        k = 0;
        while (!job_valid && k < 20) begin
            tick();
            k++;
        end
        checkOutput("done_to_valid_cycles", k, 4);
        for (int i = 0; i < 4; i++) begin
            takeJob();
            finishJob(1);
        end
        repeat (4) tick();

        $display("[TB] push and pop in the same cycle");
        applyStimulus(4'd6, expRecipe(4'd6));
        takeJob();
        applyStimulus(4'd5, expRecipe(4'd5));
        applyStimulus(4'd3, expRecipe(4'd3));
        job_done = 1'b1;
        tick();
        job_done = 1'b0;
        repeat (2) tick();
        checkOutput("pp_idle", busy, 0);
        checkOutput("pp_pending_before", pending, 2);
        order_valid = 1'b1;
        order_color = 4'd1;
        tick();
        order_valid = 1'b0;
        sb.push_back(expRecipe(4'd1));
        checkOutput("pp_pending_after", pending, 2);
        for (int i = 0; i < 3; i++) begin
            takeJob();
            finishJob(0);
        end
        repeat (4) tick();

        $display("[TB] reset while busy with orders queued");
        applyStimulus(4'd2, expRecipe(4'd2));
        takeJob();
        applyStimulus(4'd4, expRecipe(4'd4));
        applyStimulus(4'd5, expRecipe(4'd5));
        applyStimulus(4'd6, expRecipe(4'd6));
        checkOutput("pre_rst_pending", pending, 3);
        rst = 1'b1;
        #1;
        sb.delete();
        checkOutput("mid_rst_valid", job_valid, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_pending", pending, 0);
        checkOutput("mid_rst_ready", order_ready, 1);
        checkOutput("mid_rst_job_y", job_y_rounds, 0);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        checkOutput("post_rst_no_job", job_valid, 0);
        checkOutput("post_rst_idle", busy, 0);

        $display("[TB] vector table");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].color, vecs[i].job);
            checkOutput("vec_err", order_err, 32'(vecs[i].err));
            if (vecs[i].err) begin
                checkOutput("vec_err_pending", pending, 0);
                tick();
                checkOutput("vec_err_end", order_err, 0);
            end else begin
                takeJob();
                finishJob(2);
            end
        end
        repeat (4) tick();

`ifdef JOB_TIMEOUT_EN
        $display("[TB] watchdog");
        applyStimulus(4'd1, expRecipe(4'd1));
        applyStimulus(4'd2, expRecipe(4'd2));
        takeJob();
        k = 0;
        while (!job_abort && k < 100) begin
            tick();
            k++;
        end
        checkOutput("abort_cycles", k, TIMEOUT_CYCLES);
        checkOutput("abort_busy", busy, 1);
        tick();
        checkOutput("abort_pulse_end", job_abort, 0);
        takeJob();
        finishJob(0);
`else
        $display("[TB] no watchdog");
        applyStimulus(4'd1, expRecipe(4'd1));
        takeJob();
        repeat (TIMEOUT_CYCLES + 10) tick();
        checkOutput("no_abort", job_abort, 0);
        checkOutput("still_busy", busy, 1);
        finishJob(0);
`endif
        repeat (4) tick();
        checkOutput("final_idle", busy, 0);
        checkOutput("final_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
